// File: rtl/sync_ram_clr.sv
// rtl/sync_ram_clr.sv - single-port synchronous RAM with registered read and full-array clear sweep
module sync_ram_clr #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              rej
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              rd_acc;
  logic              req_drop;

  // State register; reset parks the FSM in CLEAR so the array is swept after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and array write port steering: user port in IDLE, sweep counter in CLEAR
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr;
    mem_din   = din;
    rd_acc    = 1'b0;
    req_drop  = 1'b0;
    case (state)
      IDLE: begin
        mem_we = we & rst_n;
        rd_acc = re;
        if (clr) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        mem_we   = rst_n;
        mem_addr = cnt;
        mem_din  = '0;
        req_drop = we | re;
        if (cnt == LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Sweep counter: runs only in CLEAR, held at zero otherwise so every sweep starts at word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Storage array write; deliberately not reset, the sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  // Registered read port, read-valid strobe and dropped-request pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      rej      <= 1'b0;
    end else begin
      dout_vld <= rd_acc;
      rej      <= req_drop;
      if (rd_acc) begin
        // Read and write share addr, so an accepted we here always targets the read word
        if (RDW_MODE != 0 && we) begin
          dout <= din;
        end else begin
          dout <= mem[addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_ram_clr.sv
// tb/tb_sync_ram_clr.sv - directed self-checking bench for sync_ram_clr in both read-during-write modes
module tb_sync_ram_clr;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic       re;
  logic [3:0] addr;
  logic [7:0] din;
  logic       clr;

  logic [7:0] dout0, dout1;
  logic       vld0, vld1, busy0, busy1, rej0, rej1;

  int checks = 0;
  int errors = 0;

  sync_ram_clr #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0)) u_old (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .din(din), .clr(clr),
    .dout(dout0), .dout_vld(vld0), .busy(busy0), .rej(rej0)
  );

  sync_ram_clr #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1)) u_new (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .din(din), .clr(clr),
    .dout(dout1), .dout_vld(vld1), .busy(busy1), .rej(rej1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // both instances must agree on everything except the same-address read-during-write result
  task automatic check_both(input string tag, input logic [7:0] exp_dout, input logic exp_vld,
                            input logic exp_busy, input logic exp_rej);
    check({tag, " dout0"}, dout0, exp_dout);
    check({tag, " dout1"}, dout1, exp_dout);
    check({tag, " vld0"}, vld0, exp_vld);
    check({tag, " vld1"}, vld1, exp_vld);
    check({tag, " busy0"}, busy0, exp_busy);
    check({tag, " busy1"}, busy1, exp_busy);
    check({tag, " rej0"}, rej0, exp_rej);
    check({tag, " rej1"}, rej1, exp_rej);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_rej;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; din = '0; clr = 1'b0;

    // reset state
    tick(); tick();
    check_both("reset", 8'h00, 1'b0, 1'b1, 1'b0);

    // release: busy for 16 cycles including the release cycle
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_both("release_sweep", 8'h00, 1'b0, (i < 15), 1'b0);
    end

    // every word reads zero after the power-up sweep
    for (int a = 0; a < 16; a++) begin
      re = 1'b1; addr = a[3:0];
      tick();
      check_both("read_zero", 8'h00, 1'b1, 1'b0, 1'b0);
    end
    re = 1'b0;
    tick();
    check_both("read_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // write then read back
    we = 1'b1; addr = 4'd3; din = 8'hA5;
    tick();
    check_both("write_a5", 8'h00, 1'b0, 1'b0, 1'b0);
    we = 1'b0; re = 1'b1;
    tick();
    check_both("read_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    re = 1'b0;
    tick();
    check_both("hold_a5", 8'hA5, 1'b0, 1'b0, 1'b0);

    // read-during-write on address 7
    we = 1'b1; addr = 4'd7; din = 8'h11;
    tick();
    re = 1'b1; din = 8'h22;
    tick();
    check("rdw old dout0", dout0, 8'h11);
    check("rdw new dout1", dout1, 8'h22);
    check("rdw vld0", vld0, 1'b1);
    check("rdw vld1", vld1, 1'b1);
    we = 1'b0;
    tick();
    check_both("rdw_after", 8'h22, 1'b1, 1'b0, 1'b0);
    re = 1'b0;

    // fill all words with 0xFF
    we = 1'b1; din = 8'hFF;
    for (int a = 0; a < 16; a++) begin
      addr = a[3:0];
      tick();
    end
    we = 1'b0;

    // clr cycle with simultaneous accepted we (addr 2) and re (addr 2 reads old 0xFF)
    clr = 1'b1; we = 1'b1; re = 1'b1; addr = 4'd2; din = 8'h5A;
    tick();
    check("clr_cycle dout0", dout0, 8'hFF);
    check("clr_cycle dout1", dout1, 8'h5A);
    check("clr_cycle busy0", busy0, 1'b1);
    check("clr_cycle rej0", rej0, 1'b0);
    check("clr_cycle vld0", vld0, 1'b1);
    clr = 1'b0; we = 1'b0; re = 1'b0;

    // requests during the sweep are dropped and flagged; a clr mid-sweep is ignored
    for (int i = 0; i < 16; i++) begin
      re = (i % 4 == 0);
      clr = (i == 6);
      we = (i == 9);
      addr = 4'd0; din = 8'h77;
      exp_rej = re | we;
      tick();
      check("sweep dout0", dout0, 8'hFF);
      check("sweep dout1", dout1, 8'h5A);
      check("sweep vld0", vld0, 1'b0);
      check("sweep busy0", busy0, (i < 15));
      check("sweep busy1", busy1, (i < 15));
      check("sweep rej0", rej0, exp_rej);
      check("sweep rej1", rej1, exp_rej);
    end
    re = 1'b0; clr = 1'b0; we = 1'b0;

    for (int a = 0; a < 16; a++) begin
      re = 1'b1; addr = a[3:0];
      tick();
      check_both("read_cleared", 8'h00, 1'b1, 1'b0, 1'b0);
    end
    re = 1'b0;

    // reset at sweep cycle 5 for two cycles, with a read held during reset
    we = 1'b1; addr = 4'd9; din = 8'h3C;
    tick();
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_both("pre_reset", 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0; re = 1'b1; addr = 4'd9;
    #1;
    check_both("reset_async", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_both("reset_hold1", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_both("reset_hold2", 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1; re = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_both("restart_sweep", 8'h00, 1'b0, (i < 15), 1'b0);
    end
    re = 1'b1; addr = 4'd15;
    tick();
    check_both("post_reset_rd15", 8'h00, 1'b1, 1'b0, 1'b0);
    re = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_ram_clr.md
SYNC_RAM_CLR -- requirements
Module: sync_ram_clr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning the word width in bits (1..64).
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter RDW_MODE, default 0, meaning same-address read-during-write returns the old word (0) or the new din (1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port we, input, 1 bit: write enable.
REQ-007 The block SHALL have port re, input, 1 bit: read enable.
REQ-008 The block SHALL have port addr, input, ADDR_W bits: the shared read/write address.
REQ-009 The block SHALL have port din, input, DATA_W bits: write data.
REQ-010 The block SHALL have port clr, input, 1 bit: single-cycle request to zero the whole array.
REQ-011 The block SHALL have port dout, output, DATA_W bits: registered read data.
REQ-012 The block SHALL have port dout_vld, output, 1 bit: dout was updated by an accepted read this cycle.
REQ-013 The block SHALL have port busy, output, 1 bit: clear sweep is in progress and user requests are not accepted.
REQ-014 The block SHALL have port rej, output, 1 bit: a one-cycle pulse, the cycle after a we or re was dropped while busy.

Function
REQ-015 The block SHALL contain a DEPTH x DATA_W storage array, synchronous write and synchronous read, with no combinational read path.
REQ-016 A request is accepted when busy=0; an accepted we SHALL write din to mem[addr] at that clk edge.
REQ-017 An accepted re SHALL load dout with mem[addr] at that edge (1-cycle latency), and dout_vld SHALL be 1 for exactly that following cycle.
REQ-018 With no accepted re, dout SHALL hold its last value and dout_vld SHALL be 0.
REQ-019 When we and re are accepted in the same cycle, both SHALL be performed; for the same address, dout SHALL be the old word if RDW_MODE=0 and din if RDW_MODE=1.
REQ-020 The FSM SHALL have exactly two states, IDLE and CLEAR; busy SHALL be 1 if and only if the state is CLEAR.
REQ-021 In CLEAR, an ADDR_W-bit sweep counter starting at 0 SHALL write 0 to mem[cnt] each cycle and increment.
REQ-022 At cnt = DEPTH-1, CLEAR SHALL write that last word and go to IDLE on the same edge, so the sweep takes exactly DEPTH cycles.
REQ-023 A clr in IDLE SHALL move the FSM to CLEAR with cnt=0 on the next edge; user we/re in that same clr cycle SHALL still be accepted, and the sweep SHALL overwrite them.
REQ-024 A clr asserted during CLEAR SHALL be ignored: no restart and no rej.
REQ-025 A we or re asserted during CLEAR SHALL have no effect on the array or dout and SHALL produce rej=1 on the next cycle.
REQ-026 The sweep counter SHALL not wrap into a second pass.

Reset
REQ-027 While rst_n=0, the block SHALL force dout=0, dout_vld=0, rej=0, and cnt=0.
REQ-028 While rst_n=0, the FSM SHALL be held in CLEAR, so busy=1 immediately.
REQ-029 The array SHALL not be asynchronously reset; after rst_n deasserts, the sweep SHALL zero it in DEPTH cycles.
REQ-030 A reset asserted mid-sweep or mid-read SHALL abort the operation and restart the full sweep once rst_n deasserts.

Verification
REQ-031 Reset release check (DATA_W=8, ADDR_W=4): busy SHALL stay 1 for 16 cycles after rst_n rises, then fall; reading addresses 0..15 SHALL return 0x00 each, with dout_vld high one cycle after each re.
REQ-032 Write/read check: write 0xA5 to address 3, then re at address 3 on the next cycle; dout SHALL be 0xA5 with dout_vld=1 one cycle after the re.
REQ-033 Read-during-write check: with mem[7]=0x11, we+re to address 7 with din=0x22; dout SHALL be 0x11 for RDW_MODE=0 and 0x22 for RDW_MODE=1.
REQ-034 Clear-with-requests check: fill all words with 0xFF, pulse clr, then drive re during the sweep; rej SHALL pulse once per dropped request and dout SHALL be unchanged, and all words SHALL read 0x00 afterwards.
REQ-035 Reset-mid-sweep check: drop rst_n at sweep cycle 5 for 2 cycles; busy SHALL stay 1 for 16 full cycles after release, and no dout_vld or rej SHALL occur during reset.
